// File: rtl/uart_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_fifo_pkg
// Purpose  : Shared defaults and width helper for the UART byte-path FIFO.
// Revision : 1.0 - initial release
// ============================================================================
package uart_fifo_pkg;

  localparam int c_DEFAULT_DATA_W = 8;
  localparam int c_DEFAULT_ADDR_W = 4;

  // Occupancy must represent 0..DEPTH inclusive, hence one extra bit.
  function automatic int count_width(input int addr_w);
    return addr_w + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_fifo_ram.sv
`default_nettype none
// ============================================================================
// Module   : uart_fifo_ram
// Purpose  : DEPTH x DATA_W storage, synchronous write, asynchronous read.
// Revision : 1.0 - initial release
// ============================================================================
module uart_fifo_ram
  import uart_fifo_pkg::*;
#(
  parameter int DATA_W = c_DEFAULT_DATA_W,
  parameter int ADDR_W = c_DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int c_DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [c_DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/uart_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_fifo_ctrl
// Purpose  : FWFT synchronous FIFO with count, flush and sticky error flags.
//            Watermark flags enabled by defining UART_FIFO_WATERMARK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module uart_fifo_ctrl
  import uart_fifo_pkg::*;
#(
  parameter int DATA_W = c_DEFAULT_DATA_W,
  parameter int ADDR_W = c_DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd,
  output logic [DATA_W-1:0] rd_data,
  input  logic              flush,
  input  logic              err_clr,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow,
  input  logic [ADDR_W:0]   af_thresh,
  input  logic [ADDR_W:0]   ae_thresh,
  output logic              almost_full,
  output logic              almost_empty
);

  localparam int                   c_COUNT_W = count_width(ADDR_W);
  localparam logic [c_COUNT_W-1:0] c_DEPTH   = c_COUNT_W'(1 << ADDR_W);

  logic [ADDR_W-1:0]    r_wr_ptr;
  logic [ADDR_W-1:0]    r_rd_ptr;
  logic [c_COUNT_W-1:0] r_count;
  logic [c_COUNT_W-1:0] w_count_nxt;
  logic                 r_empty;
  logic                 r_full;
  logic                 r_overflow;
  logic                 r_underflow;
  logic                 w_rd_accept;
  logic                 w_wr_accept;
  logic                 w_wr_en;
  logic                 w_rd_en;

  // A write into a full queue is still taken when the head leaves this cycle.
  assign w_rd_accept = rd & ~r_empty;
  assign w_wr_accept = wr & (~r_full | w_rd_accept);
  assign w_wr_en     = w_wr_accept & ~flush;
  assign w_rd_en     = w_rd_accept & ~flush;

  always_comb begin
    w_count_nxt = r_count;
    if (flush) begin
      w_count_nxt = '0;
    end else if (w_wr_en && !w_rd_en) begin
      w_count_nxt = r_count + c_COUNT_W'(1);
    end else if (!w_wr_en && w_rd_en) begin
      w_count_nxt = r_count - c_COUNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_empty     <= 1'b1;
      r_full      <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_wr_en) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
        if (w_rd_en) r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      end
      r_count <= w_count_nxt;
      r_empty <= (w_count_nxt == '0);
      r_full  <= (w_count_nxt == c_DEPTH);
      // Set has priority over clear so a coincident error is never lost.
      if (wr && !w_wr_accept && !flush) r_overflow <= 1'b1;
      else if (err_clr)                 r_overflow <= 1'b0;
      if (rd && !w_rd_accept && !flush) r_underflow <= 1'b1;
      else if (err_clr)                 r_underflow <= 1'b0;
    end
  end

  uart_fifo_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_wr_en),
    .i_waddr (r_wr_ptr),
    .i_wdata (wr_data),
    .i_raddr (r_rd_ptr),
    .o_rdata (rd_data)
  );

  assign empty     = r_empty;
  assign full      = r_full;
  assign count     = r_count;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

`ifdef UART_FIFO_WATERMARK_EN
  logic r_almost_full;
  logic r_almost_empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_almost_full  <= 1'b0;
      r_almost_empty <= 1'b1;
    end else begin
      r_almost_full  <= (w_count_nxt >= af_thresh);
      r_almost_empty <= (w_count_nxt <= ae_thresh);
    end
  end

  assign almost_full  = r_almost_full;
  assign almost_empty = r_almost_empty;
`else
  logic w_unused_thresh;
  assign w_unused_thresh = ^{af_thresh, ae_thresh};
  assign almost_full     = 1'b0;
  assign almost_empty    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_fifo_ctrl
// Purpose  : Scoreboard bench for uart_fifo_ctrl (honours UART_FIFO_WATERMARK_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_fifo_ctrl;

  localparam int c_DW    = 8;
  localparam int c_AW    = 4;
  localparam int c_DEPTH = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              wr = 1'b0;
  logic              rd = 1'b0;
  logic              flush = 1'b0;
  logic              err_clr = 1'b0;
  logic [c_DW-1:0]   wr_data = '0;
  logic [c_DW-1:0]   rd_data;
  logic              empty, full, overflow, underflow;
  logic              almost_full, almost_empty;
  logic [c_AW:0]     count;
  logic [c_AW:0]     af_thresh = 5'd12;
  logic [c_AW:0]     ae_thresh = 5'd2;

  int              n_checks = 0;
  int              n_errors = 0;
  logic [c_DW-1:0] sb_q[$];
  bit              m_ovf = 1'b0;
  bit              m_udf = 1'b0;
  logic [c_DW-1:0] r_last_dut_pop = '0;

  always #5 clk = ~clk;

  uart_fifo_ctrl #(.DATA_W(c_DW), .ADDR_W(c_AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .wr           (wr),
    .wr_data      (wr_data),
    .rd           (rd),
    .rd_data      (rd_data),
    .flush        (flush),
    .err_clr      (err_clr),
    .empty        (empty),
    .full         (full),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow),
    .af_thresh    (af_thresh),
    .ae_thresh    (ae_thresh),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic check_status(input string tag);
    int n;
    n = sb_q.size();
    check_eq({tag, ".count"}, 32'(count), 32'(n));
    check_eq({tag, ".empty"}, 32'(empty), 32'(n == 0));
    check_eq({tag, ".full"}, 32'(full), 32'(n == c_DEPTH));
    check_eq({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
    check_eq({tag, ".underflow"}, 32'(underflow), 32'(m_udf));
`ifdef UART_FIFO_WATERMARK_EN
    check_eq({tag, ".almost_full"}, 32'(almost_full), 32'(n >= int'(af_thresh)));
    check_eq({tag, ".almost_empty"}, 32'(almost_empty), 32'(n <= int'(ae_thresh)));
`else
    check_eq({tag, ".almost_full"}, 32'(almost_full), 32'(0));
    check_eq({tag, ".almost_empty"}, 32'(almost_empty), 32'(0));
`endif
  endtask

  // Called at a negedge: drives one cycle, scores the data path, checks status.
  task automatic step(input bit w, input logic [c_DW-1:0] d, input bit r,
                      input bit f, input bit c);
    bit              rd_acc;
    bit              wr_acc;
    logic [c_DW-1:0] exp_word;
    wr = w; wr_data = d; rd = r; flush = f; err_clr = c;
    rd_acc = r && (sb_q.size() > 0);
    wr_acc = w && ((sb_q.size() < c_DEPTH) || rd_acc);
    if (sb_q.size() > 0 && !(rd_acc && !f)) check_eq("head", 32'(rd_data), 32'(sb_q[0]));
    if (f) begin
      sb_q.delete();
    end else begin
      if (rd_acc) begin
        exp_word = sb_q.pop_front();
        check_eq("pop", 32'(rd_data), 32'(exp_word));
        r_last_dut_pop = rd_data;
      end
      if (wr_acc) sb_q.push_back(d);
    end
    if (!f && w && !wr_acc) m_ovf = 1'b1;
    else if (c)             m_ovf = 1'b0;
    if (!f && r && !rd_acc) m_udf = 1'b1;
    else if (c)             m_udf = 1'b0;
    @(posedge clk);
    @(negedge clk);
    wr = 1'b0; rd = 1'b0; flush = 1'b0; err_clr = 1'b0;
    check_status("st");
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_status("reset");
    reset = 1'b1;
    @(negedge clk);

    // Basic FWFT ordering
    step(1, 8'h11, 0, 0, 0);
    step(1, 8'h22, 0, 0, 0);
    step(1, 8'h33, 0, 0, 0);
    check_eq("t1_head", 32'(rd_data), 32'h11);
    repeat (3) step(0, 8'h00, 1, 0, 0);

    // Fill to full, then a rejected write
    for (int i = 0; i < c_DEPTH; i++) step(1, 8'(8'h40 + i), 0, 0, 0);
    step(1, 8'hAA, 0, 0, 0);
    step(0, 8'h00, 0, 0, 1);

    // Simultaneous read/write while full, then drain
    step(1, 8'h5C, 1, 0, 0);
    for (int i = 0; i < c_DEPTH; i++) step(0, 8'h00, 1, 0, 0);
    check_eq("t3_last_word", 32'(r_last_dut_pop), 32'h5C);

    // Empty with wr & rd: write wins, underflow raised; clear/set priority
    step(1, 8'h7E, 1, 0, 0);
    check_eq("t4_rd_data", 32'(rd_data), 32'h7E);
    step(0, 8'h00, 0, 0, 1);
    step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 1, 0, 1);
    step(0, 8'h00, 0, 0, 1);

    // Flush with a coincident write
    for (int i = 0; i < 10; i++) step(1, 8'(8'hA0 + i), 0, 0, 0);
    step(1, 8'hEE, 0, 1, 0);

    // Pointer wrap with one word in flight
    step(1, 8'h80, 0, 0, 0);
    for (int i = 1; i < 40; i++) step(1, 8'(8'h80 + i), 1, 0, 0);
    step(0, 8'h00, 1, 0, 0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(bit'($urandom_range(0, 99) < 55), 8'($urandom), bit'($urandom_range(0, 99) < 45),
           bit'($urandom_range(0, 63) == 0), bit'($urandom_range(0, 15) == 0));
    end

    // Asynchronous reset mid-operation
    for (int i = 0; i < 5; i++) step(1, 8'(8'hC0 + i), 0, 0, 0);
    reset = 1'b0;
    #1;
    sb_q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    check_status("midreset");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    step(1, 8'h3C, 0, 0, 0);
    step(0, 8'h00, 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_fifo_ctrl.md
Name: uart_fifo_ctrl

Overview:
Parametrised synchronous FIFO for the UART TX/RX byte paths. It is the successor to the current simple FIFO.
- Adds configurable width and depth, an occupancy count and first-word-fall-through read data.
- Handles simultaneous read/write correctly at the full and empty boundaries.
- Provides synchronous flush, sticky overflow/underflow error flags and optional watermark flags.
- Sits between the UART rx/tx engines and the bus-side register interface.

Parameters:
DATA_W, 8, data word width in bits
ADDR_W, 4, log2 of depth; DEPTH = 2**ADDR_W entries, ADDR_W >= 1

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
wr  in  1  write request
wr_data  in  DATA_W  write data
rd  in  1  read request (pop)
rd_data  out  DATA_W  head-of-queue data (FWFT)
flush  in  1  synchronous clear of queue contents
err_clr  in  1  clears sticky error flags
empty  out  1  queue empty
full  out  1  queue full
count  out  ADDR_W+1  occupancy, 0..DEPTH
overflow  out  1  sticky: write rejected
underflow  out  1  sticky: read rejected
af_thresh  in  ADDR_W+1  almost-full threshold
ae_thresh  in  ADDR_W+1  almost-empty threshold
almost_full  out  1  count >= af_thresh
almost_empty  out  1  count <= ae_thresh

Behaviour:
- Decided interface: reset reset, asynchronous, active-low; clock clk. All state updates on posedge clk.
- Reset values:
  - wr_ptr = 0, rd_ptr = 0, count = 0.
  - empty = 1, full = 0, overflow = 0, underflow = 0.
  - almost_full = 0, almost_empty = 1 (0 when the macro is undefined).
  - Storage array contents are not reset.
- Pointers are ADDR_W bits and wrap naturally from DEPTH-1 to 0.
- empty, full and count are registered and derived from next count: full = (count == DEPTH), empty = (count == 0).
- rd_accept = rd & ~empty.
- wr_accept = wr & (~full | rd_accept). A write while full is accepted if a read is accepted in the same cycle.
- Accepted write: mem[wr_ptr] <= wr_data; wr_ptr++. Accepted read: rd_ptr++.
- count update:
  - +1 on write only.
  - -1 on read only.
  - Unchanged when both are accepted, or when neither is.
- rd_data = mem[rd_ptr], combinational, zero-latency FWFT.
  - Valid whenever empty = 0; don't-care when empty = 1.
  - A word written at edge N appears on rd_data after edge N if the FIFO was empty (1-cycle write-to-read latency).
- Empty plus wr & rd in the same cycle: write accepted, read rejected, underflow set. No bypass path.
- Full plus wr only: write dropped, storage unchanged, overflow set.
- flush has highest priority:
  - wr_ptr, rd_ptr and count go to 0; empty = 1, full = 0.
  - wr/rd in the same cycle are ignored and raise no error flag.
  - overflow/underflow are not affected by flush.
- overflow <= 1 when wr & ~wr_accept & ~flush.
- underflow <= 1 when rd & ~rd_accept & ~flush.
- err_clr clears both flags. If a set condition and err_clr coincide, set wins.
- Asserting reset mid-operation returns all registers to reset values immediately; an in-flight write is lost.

Optional Feature:
Macro UART_FIFO_WATERMARK_EN.
- Defined:
  - almost_full and almost_empty are registered and computed from next count, so they are cycle-aligned with count.
  - Thresholds are sampled every cycle.
  - After flush: almost_empty = 1 (unless ae_thresh would give otherwise, i.e. 0 <= ae_thresh always holds) and almost_full = (af_thresh == 0).
- Undefined: almost_full and almost_empty are tied to 0, af_thresh/ae_thresh are ignored and no watermark logic is synthesised.

Decomposition:
- Package uart_fifo_pkg:
  - default DATA_W/ADDR_W constants.
  - function for count-width calculation (ADDR_W+1).
- One sub-module: uart_fifo_ram.
  - DEPTH x DATA_W storage, synchronous write port, asynchronous read port.
  - Instantiated once.
- Pointer, count and flag logic stays in uart_fifo_ctrl.

Test Plan:
1. Reset, then write 0x11,0x22,0x33 -> count = 3, empty = 0, rd_data = 0x11; three pops give 0x11, 0x22, 0x33, then empty = 1, count = 0.
2. ADDR_W = 4: write 16 words -> full = 1, count = 16. Write 0xAA alone -> overflow = 1, count stays 16, last popped word is not 0xAA.
3. When full, wr = rd = 1 with 0x5C -> head popped, 0x5C accepted, count stays 16, full stays 1, no overflow. Then drain 16 words; the last word is 0x5C.
4. When empty, wr = rd = 1 with 0x7E -> count = 1, underflow = 1, rd_data = 0x7E next cycle. err_clr pulse -> underflow = 0. err_clr coincident with a new underflow -> underflow stays 1.
5. Load 10 words, pulse flush with wr = 1 -> count = 0, empty = 1, overflow = 0. Wrap test: 40 write/read cycles give data in order across pointer wrap.
6. UART_FIFO_WATERMARK_EN defined, af_thresh = 12, ae_thresh = 2 -> almost_empty deasserts on the edge count goes 2->3, almost_full asserts on the edge count reaches 12. Undefined -> both outputs 0 throughout.
